// File: rtl/keypad_scanner.sv
// keypad_scanner
//   Scans a 4x4 active-low matrix keypad, debounces the selected key and
//   hands one clean 4-bit key code to the opcode decoder / operand entry
//   logic. Codes 0000-1001 are digits, 1010-1101 are op keys.
//
// Ports
//   clk        : system clock, everything on the rising edge
//   rst        : synchronous active-high reset
//   col_n[3:0] : keypad columns, active-low, pulled up, asynchronous
//   row_n[3:0] : keypad row drive, one-hot active-low
//   key_code   : last accepted key = {row_idx[1:0], col_idx[1:0]}
//   key_strobe : one-cycle pulse, key_code valid
//   key_held   : high from the strobe cycle until the release is debounced
//
// Parameters
//   SCAN_DWELL      : cycles each row is driven before sampling (>= 3)
//   DEBOUNCE_CYCLES : consecutive stable cycles to accept press/release (>= 1)
//   REPEAT_CYCLES   : auto-repeat interval (>= 2), only with KEYPAD_REPEAT_EN
//
// Build option
//   KEYPAD_REPEAT_EN : when defined, a held key re-strobes every
//                      REPEAT_CYCLES cycles spent in HOLD. When undefined,
//                      exactly one strobe per debounced press.

module keypad_scanner #(
   parameter int SCAN_DWELL      = 4,
   parameter int DEBOUNCE_CYCLES = 8
`ifdef KEYPAD_REPEAT_EN
   ,
   parameter int REPEAT_CYCLES   = 64
`endif
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [3:0] col_n,
   output logic [3:0] row_n,
   output logic [3:0] key_code,
   output logic       key_strobe,
   output logic       key_held
);

   localparam int DWELL_W = $clog2(SCAN_DWELL) + 1;
   localparam int DEB_W   = $clog2(DEBOUNCE_CYCLES) + 1;

   localparam logic [DWELL_W-1:0] DWELL_LAST = DWELL_W'(SCAN_DWELL - 1);
   localparam logic [DWELL_W-1:0] DWELL_ONE  = DWELL_W'(1);
   localparam logic [DEB_W-1:0]   DEB_LAST   = DEB_W'(DEBOUNCE_CYCLES - 1);
   localparam logic [DEB_W-1:0]   DEB_ONE    = DEB_W'(1);

`ifdef KEYPAD_REPEAT_EN
   localparam int REP_W = $clog2(REPEAT_CYCLES) + 1;
   localparam logic [REP_W-1:0] REP_LAST = REP_W'(REPEAT_CYCLES - 1);
   localparam logic [REP_W-1:0] REP_ONE  = REP_W'(1);
`endif

   typedef enum logic [1:0] {
      ST_SCAN     = 2'd0,
      ST_DEBOUNCE = 2'd1,
      ST_HOLD     = 2'd2,
      ST_RELEASE  = 2'd3
   } state_t;

   // registered state
   logic [3:0]         r_col_meta;
   logic [3:0]         r_col_s;
   state_t             r_state;
   logic [1:0]         r_row_idx;
   logic [DWELL_W-1:0] r_dwell;
   logic [DEB_W-1:0]   r_deb_cnt;
   logic [1:0]         r_cap_col;
   logic [3:0]         r_key_code;
   logic               r_key_strobe;
   logic               r_key_held;

   // next-state values
   state_t             w_state_next;
   logic [1:0]         w_row_idx_next;
   logic [DWELL_W-1:0] w_dwell_next;
   logic [DEB_W-1:0]   w_deb_cnt_next;
   logic [1:0]         w_cap_col_next;
   logic [3:0]         w_key_code_next;
   logic               w_key_strobe_next;
   logic               w_key_held_next;

`ifdef KEYPAD_REPEAT_EN
   logic [REP_W-1:0]   r_rep_cnt;
   logic [REP_W-1:0]   w_rep_cnt_next;
`endif

   // combinational helpers on the synchronized columns
   logic               w_any_low;
   logic [1:0]         w_low_col;
   logic               w_cap_high;

   assign w_any_low  = ~&r_col_s;
   assign w_cap_high = r_col_s[r_cap_col];

   // Lowest-index low column wins: scanning downward lets col 0 override.
   always_comb begin
      w_low_col = 2'd0;
      for (int i = 3; i >= 0; i--) begin
         if (!r_col_s[i]) begin
            w_low_col = 2'(i);
         end
      end
   end

   // Row drive is decoded straight from the row index; during DEBOUNCE,
   // HOLD and RELEASE the index is simply not advanced, which freezes it.
   assign row_n      = ~(4'b0001 << r_row_idx);
   assign key_code   = r_key_code;
   assign key_strobe = r_key_strobe;
   assign key_held   = r_key_held;

   always_comb begin
      w_state_next      = r_state;
      w_row_idx_next    = r_row_idx;
      w_dwell_next      = r_dwell;
      w_deb_cnt_next    = r_deb_cnt;
      w_cap_col_next    = r_cap_col;
      w_key_code_next   = r_key_code;
      w_key_strobe_next = 1'b0;
      w_key_held_next   = r_key_held;
`ifdef KEYPAD_REPEAT_EN
      // Only a cycle that stays in HOLD keeps the repeat count alive.
      w_rep_cnt_next    = '0;
`endif

      case (r_state)
         ST_SCAN: begin
            if (r_dwell == DWELL_LAST) begin
               w_dwell_next = '0;
               if (w_any_low) begin
                  w_cap_col_next = w_low_col;
                  w_deb_cnt_next = '0;
                  w_state_next   = ST_DEBOUNCE;
               end else begin
                  w_row_idx_next = r_row_idx + 2'd1;
               end
            end else begin
               w_dwell_next = r_dwell + DWELL_ONE;
            end
         end

         ST_DEBOUNCE: begin
            if (!w_cap_high) begin
               if (r_deb_cnt == DEB_LAST) begin
                  w_deb_cnt_next    = '0;
                  w_key_code_next   = {r_row_idx, r_cap_col};
                  w_key_strobe_next = 1'b1;
                  w_key_held_next   = 1'b1;
                  w_state_next      = ST_HOLD;
               end else begin
                  w_deb_cnt_next = r_deb_cnt + DEB_ONE;
               end
            end else begin
               // bounce: drop the candidate and move on to the next row
               w_deb_cnt_next = '0;
               w_row_idx_next = r_row_idx + 2'd1;
               w_dwell_next   = '0;
               w_state_next   = ST_SCAN;
            end
         end

         ST_HOLD: begin
            if (w_cap_high) begin
               // The cycle that first sees the column high is the first
               // of the consecutive highs needed for release.
               if (DEB_LAST == '0) begin
                  w_key_held_next = 1'b0;
                  w_row_idx_next  = r_row_idx + 2'd1;
                  w_dwell_next    = '0;
                  w_deb_cnt_next  = '0;
                  w_state_next    = ST_SCAN;
               end else begin
                  w_deb_cnt_next = DEB_ONE;
                  w_state_next   = ST_RELEASE;
               end
            end else begin
`ifdef KEYPAD_REPEAT_EN
               if (r_rep_cnt == REP_LAST) begin
                  w_key_strobe_next = 1'b1;
                  w_rep_cnt_next    = '0;
               end else begin
                  w_rep_cnt_next = r_rep_cnt + REP_ONE;
               end
`endif
            end
         end

         ST_RELEASE: begin
            if (!w_cap_high) begin
               w_deb_cnt_next = '0;
               w_state_next   = ST_HOLD;
            end else if (r_deb_cnt == DEB_LAST) begin
               w_deb_cnt_next  = '0;
               w_key_held_next = 1'b0;
               w_row_idx_next  = r_row_idx + 2'd1;
               w_dwell_next    = '0;
               w_state_next    = ST_SCAN;
            end else begin
               w_deb_cnt_next = r_deb_cnt + DEB_ONE;
            end
         end

         default: begin
            w_state_next = ST_SCAN;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_col_meta   <= 4'b1111;
         r_col_s      <= 4'b1111;
         r_state      <= ST_SCAN;
         r_row_idx    <= 2'd0;
         r_dwell      <= '0;
         r_deb_cnt    <= '0;
         r_cap_col    <= 2'd0;
         r_key_code   <= 4'b0000;
         r_key_strobe <= 1'b0;
         r_key_held   <= 1'b0;
`ifdef KEYPAD_REPEAT_EN
         r_rep_cnt    <= '0;
`endif
      end else begin
         r_col_meta   <= col_n;
         r_col_s      <= r_col_meta;
         r_state      <= w_state_next;
         r_row_idx    <= w_row_idx_next;
         r_dwell      <= w_dwell_next;
         r_deb_cnt    <= w_deb_cnt_next;
         r_cap_col    <= w_cap_col_next;
         r_key_code   <= w_key_code_next;
         r_key_strobe <= w_key_strobe_next;
         r_key_held   <= w_key_held_next;
`ifdef KEYPAD_REPEAT_EN
         r_rep_cnt    <= w_rep_cnt_next;
`endif
      end
   end

endmodule

// File: tb/tb_keypad_scanner.sv
// tb_keypad_scanner
//   Self-checking bench for keypad_scanner. A keypad matrix model drives
//   col_n from the row drive and a table of pressed keys. Expected codes,
//   strobe counts and timing windows come from the key-press rules:
//   code = {row, lowest pressed column}, latency bounded by sync + one full
//   scan + debounce, release seen DEBOUNCE_CYCLES after the synchronized
//   column goes high, and (with KEYPAD_REPEAT_EN) one extra strobe per
//   REPEAT_CYCLES cycles spent holding.

module tb_keypad_scanner;

   localparam int SCAN_DWELL      = 4;
   localparam int DEBOUNCE_CYCLES = 8;
`ifdef KEYPAD_REPEAT_EN
   localparam int REPEAT_CYCLES   = 16;
`endif
   localparam int LAT_MAX = 2 + 4 * SCAN_DWELL + DEBOUNCE_CYCLES;
   localparam int LAT_MIN = DEBOUNCE_CYCLES + 3;

   logic       clk = 1'b0;
   logic       rst;
   logic [3:0] col_n;
   logic [3:0] row_n;
   logic [3:0] key_code;
   logic       key_strobe;
   logic       key_held;

   logic [3:0] pressed [4];

   int n_vec = 0;
   int n_err = 0;
   int cyc = 0;

   // strobe bookkeeping shared between monitor and stimulus
   int         n_strobe = 0;
   int         ep_base = 0;
   int         first_strobe_cyc = 0;
   logic [3:0] first_strobe_code = 4'b0000;
   logic [3:0] last_strobe_code = 4'b0000;
   logic [3:0] model_code = 4'b0000;
   logic       mon_en = 1'b0;
   logic       rst_at_edge;
   logic       prev_strobe = 1'b0;
   logic [3:0] prev_code = 4'b0000;

   always #5 clk = ~clk;

   always @(posedge clk) begin
      cyc         <= cyc + 1;
      rst_at_edge <= rst;
   end

   // keypad matrix: a column is pulled low by any pressed key on a driven row
   always_comb begin
      col_n = 4'b1111;
      for (int r = 0; r < 4; r++) begin
         for (int c = 0; c < 4; c++) begin
            if (pressed[r][c] && !row_n[r]) begin
               col_n[c] = 1'b0;
            end
         end
      end
   end

   keypad_scanner #(
      .SCAN_DWELL     (SCAN_DWELL),
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
`ifdef KEYPAD_REPEAT_EN
      ,
      .REPEAT_CYCLES  (REPEAT_CYCLES)
`endif
   ) u_dut (
      .clk       (clk),
      .rst       (rst),
      .col_n     (col_n),
      .row_n     (row_n),
      .key_code  (key_code),
      .key_strobe(key_strobe),
      .key_held  (key_held)
   );

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [1:0] low_col(input logic [3:0] m);
      for (int i = 0; i < 4; i++) begin
         if (m[i]) return 2'(i);
      end
      return 2'd0;
   endfunction

   // Continuous protocol checks, sampled on the falling edge.
   always @(negedge clk) begin
      if (mon_en && !rst_at_edge) begin
         check_val("strobe_gap", 32'(prev_strobe & key_strobe), 0);
         if (!key_strobe) check_val("code_stable", key_code, prev_code);
         check_val("row_onehot", $countones(~row_n), 1);
         if (key_strobe) begin
            if (n_strobe == ep_base) begin
               first_strobe_cyc  = cyc;
               first_strobe_code = key_code;
            end
            last_strobe_code = key_code;
            n_strobe++;
         end
      end
      prev_strobe = key_strobe;
      prev_code   = key_code;
   end

   // One full press: hold the mask on a row for hold_cyc cycles, then release.
   task automatic run_press(input string tag, input int row, input logic [3:0] mask,
                            input int hold_cyc);
      logic [3:0] exp_code;
      int c0, c1, lat, n_exp, i;
      exp_code = {2'(row), low_col(mask)};
      ep_base = n_strobe;
      pressed[row] = mask;
      c0 = cyc;
      i = 0;
      while (n_strobe == ep_base && i < LAT_MAX + 4) begin
         tick();
         i++;
      end
      lat = first_strobe_cyc - c0;
      if (n_strobe == ep_base) begin
         check_val({tag, "_strobe_seen"}, 0, 1);
      end else begin
         check_val({tag, "_lat_max"}, 32'(lat <= LAT_MAX), 1);
         check_val({tag, "_lat_min"}, 32'(lat >= LAT_MIN), 1);
         check_val({tag, "_code"}, first_strobe_code, exp_code);
      end
      while (cyc - c0 < hold_cyc) tick();
      check_val({tag, "_held_on"}, key_held, 1);
      check_val({tag, "_code_hold"}, key_code, exp_code);
      pressed[row] = 4'b0000;
      c1 = cyc;
      for (int k = 1; k <= DEBOUNCE_CYCLES + 2; k++) begin
         tick();
         if (k == DEBOUNCE_CYCLES + 1) check_val({tag, "_held_late"}, key_held, 1);
         if (k == DEBOUNCE_CYCLES + 2) check_val({tag, "_held_drop"}, key_held, 0);
      end
      repeat (4) tick();
`ifdef KEYPAD_REPEAT_EN
      n_exp = 1 + (c1 + 2 - first_strobe_cyc) / REPEAT_CYCLES;
`else
      n_exp = 1;
`endif
      check_val({tag, "_n_strobe"}, n_strobe - ep_base, n_exp);
      check_val({tag, "_last_code"}, last_strobe_code, exp_code);
      model_code = exp_code;
      $display("press %s row=%0d mask=%b code=%b lat=%0d strobes=%0d",
               tag, row, mask, key_code, lat, n_strobe - ep_base);
   endtask

   // Short glitch shorter than the debounce window: must never strobe.
   task automatic run_bounce(input string tag, input int row, input logic [3:0] mask,
                             input int len);
      int s0;
      s0 = n_strobe;
      pressed[row] = mask;
      repeat (len) tick();
      pressed[row] = 4'b0000;
      repeat (30) tick();
      check_val({tag, "_no_strobe"}, n_strobe - s0, 0);
      check_val({tag, "_code_kept"}, key_code, model_code);
      $display("bounce %s row=%0d mask=%b len=%0d code=%b", tag, row, mask, len, key_code);
   endtask

   initial begin : watchdog
      #1000000;
      $display("FAIL watchdog: run still active at time limit, expected finish");
      $fatal(1, "watchdog");
   end

   initial begin : main
      int i, c0;
      for (int r = 0; r < 4; r++) pressed[r] = 4'b0000;
      rst = 1'b1;

      // reset state and idle scan pattern
      tick();
      tick();
      check_val("rst_row", row_n, 4'b1110);
      check_val("rst_code", key_code, 4'b0000);
      check_val("rst_strobe", key_strobe, 0);
      check_val("rst_held", key_held, 0);
      mon_en = 1'b1;
      rst = 1'b0;
      for (int k = 1; k <= 16; k++) begin
         tick();
         if (k == 3)  check_val("scan_k3", row_n, 4'b1110);
         if (k == 4)  check_val("scan_k4", row_n, 4'b1101);
         if (k == 8)  check_val("scan_k8", row_n, 4'b1011);
         if (k == 12) check_val("scan_k12", row_n, 4'b0111);
         if (k == 16) check_val("scan_k16", row_n, 4'b1110);
      end
      $display("reset row=%b code=%b held=%b", row_n, key_code, key_held);

      // bounce on (row3,col1) aligned to the start of row 3's dwell
      i = 0;
      while (row_n == 4'b0111 && i < 40) begin tick(); i++; end
      i = 0;
      while (row_n != 4'b0111 && i < 40) begin tick(); i++; end
      check_val("bnc_row3_found", row_n, 4'b0111);
      c0 = n_strobe;
      pressed[3] = 4'b0010;
      tick();
      tick();
      tick();
      pressed[3] = 4'b0000;
      tick();
      check_val("bnc_frozen", row_n, 4'b0111);
      tick();
      tick();
      check_val("bnc_resume", row_n, 4'b1110);
      repeat (30) tick();
      check_val("bnc_no_strobe", n_strobe - c0, 0);
      check_val("bnc_code_kept", key_code, model_code);
      $display("bounce directed row=3 col=1 code=%b", key_code);

      // directed presses
      run_press("add", 2, 4'b1000, 60);
      repeat (10) tick();
      run_press("dual", 1, 4'b1010, 50);
      repeat (10) tick();
      run_press("rep", 3, 4'b0010, 90);
      repeat (10) tick();

      // reset while a key is held in HOLD
      ep_base = n_strobe;
      pressed[1] = 4'b0100;
      i = 0;
      while (n_strobe == ep_base && i < LAT_MAX + 4) begin tick(); i++; end
      check_val("rih_first_strobe", n_strobe - ep_base, 1);
      repeat (6) tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      check_val("rih_row", row_n, 4'b1110);
      check_val("rih_held", key_held, 0);
      check_val("rih_code", key_code, 4'b0000);
      check_val("rih_strobe", key_strobe, 0);
      model_code = 4'b0000;
      ep_base = n_strobe;
      c0 = cyc;
      i = 0;
      while (n_strobe == ep_base && i < LAT_MAX + 4) begin tick(); i++; end
      check_val("rih_redetect", n_strobe - ep_base, 1);
      check_val("rih_lat", 32'(first_strobe_cyc - c0 <= LAT_MAX), 1);
      check_val("rih_new_code", first_strobe_code, 4'b0110);
      pressed[1] = 4'b0000;
      repeat (20) tick();
      check_val("rih_one_strobe", n_strobe - ep_base, 1);
      check_val("rih_released", key_held, 0);
      model_code = 4'b0110;
      $display("reset-in-hold code=%b strobes=%0d", key_code, n_strobe - ep_base);

      // randomized presses and glitches
      for (int it = 0; it < 14; it++) begin
         int row, kind, len;
         logic [3:0] mask;
         row  = $urandom_range(0, 3);
         mask = 4'($urandom_range(1, 15));
         kind = $urandom_range(0, 3);
         repeat ($urandom_range(0, 20)) tick();
         if (kind == 0) begin
            len = $urandom_range(1, 6);
            run_bounce($sformatf("rnd%0d", it), row, mask, len);
         end else begin
            run_press($sformatf("rnd%0d", it), row, mask, $urandom_range(30, 100));
         end
      end

      repeat (5) tick();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/keypad_scanner.md
Name: keypad_scanner

Overview:
Front end of the calculator input path. Scans a 4x4 active-low matrix keypad and debounces the selected key. Emits one clean 4-bit key code with a single-cycle strobe per press. Feeds the opcode decoder and operand entry logic directly: codes 1010-1101 are the op keys, 0000-1001 are digits.

Parameters:
SCAN_DWELL, 4, cycles each row is driven before the columns are sampled (min 3, covers the 2-flop synchronizer)
DEBOUNCE_CYCLES, 8, consecutive stable cycles required to accept a press or a release (min 1)
REPEAT_CYCLES, 64, auto-repeat interval in cycles (used only when KEYPAD_REPEAT_EN is defined)

Ports:
clk  input  1  system clock, all logic on rising edge
rst  input  1  reset, synchronous, active-high
col_n  input  4  keypad column lines, active-low, externally pulled up, asynchronous
row_n  output  4  keypad row drive, one-hot active-low
key_code  output  4  code of last accepted key = {row_idx[1:0], col_idx[1:0]}
key_strobe  output  1  one-cycle pulse, key_code valid
key_held  output  1  high from the strobe cycle until the release is debounced

Behaviour:
- col_n passes through a 2-flop synchronizer. All decisions use the synchronized value (col_s).
- Reset (rst high at a clk edge), next cycle:
  - state=SCAN, row_idx=0, row_n=4'b1110
  - key_code=4'b0000, key_strobe=0, key_held=0
  - all counters 0, synchronizer flops = 4'b1111
- Reset mid-operation aborts any press with no strobe.
- States: SCAN, DEBOUNCE, HOLD, RELEASE.
- SCAN:
  - Drive row_n = ~(1<<row_idx). Dwell counter counts 0..SCAN_DWELL-1.
  - On the last dwell cycle, sample col_s.
  - If no column is low: row_idx wraps 3->0, dwell counter clears.
  - If any column is low: capture row_idx and the lowest-index low column (col 0 has priority), then go to DEBOUNCE. row_n stays frozen on the captured row.
- DEBOUNCE:
  - Counter increments each cycle the captured col_s bit is 0.
  - If that bit reads 1 before DEBOUNCE_CYCLES: no strobe, counter cleared, return to SCAN at row_idx+1 (mod 4).
  - Otherwise key_strobe=1 and key_code is updated in the cycle exactly DEBOUNCE_CYCLES after DEBOUNCE was entered. key_held=1 from that same cycle, then go to HOLD.
- HOLD:
  - key_strobe=0, row frozen.
  - Stay while the captured column is low. Go to RELEASE when it is high.
  - Other keys pressed meanwhile are ignored.
- RELEASE:
  - Counts consecutive highs on the captured column.
  - A low before DEBOUNCE_CYCLES returns to HOLD with the counter cleared.
  - On reaching DEBOUNCE_CYCLES: key_held=0, return to SCAN at row_idx+1.
- key_code holds its value between strobes and changes only on a strobe cycle.
- key_strobe is never high for two consecutive cycles.
- Press-to-strobe latency: at most 2 + 4*SCAN_DWELL + DEBOUNCE_CYCLES cycles.
- Counter widths: $clog2 of their max value + 1. Counters never wrap.

Optional Feature:
KEYPAD_REPEAT_EN
- Defined: HOLD runs a repeat counter.
  - Every REPEAT_CYCLES consecutive cycles in HOLD, pulse key_strobe for one cycle with the unchanged key_code.
  - The counter clears on entry to HOLD and whenever HOLD is left, including via RELEASE->HOLD bounce.
- Undefined: exactly one key_strobe per debounced press. The repeat counter and REPEAT_CYCLES are unused and generate no logic.

Test Plan:
Bench keypad model: col_n[c] = ~|(pressed[r][c] & ~row_n[r]) over r. Parameters: SCAN_DWELL=4, DEBOUNCE_CYCLES=8, REPEAT_CYCLES=16.
1. Reset: rst=1 for 2 cycles -> row_n=1110, key_code=0000, key_strobe=0, key_held=0; with no key pressed, row_n then cycles 1101,1011,0111,1110 every 4 cycles.
2. Hold key (row2,col3) for 60 cycles, then release -> exactly one key_strobe, key_code=1011 (ADD) within 2+16+8 cycles; key_held=1 until 8 cycles after the synchronized release.
3. Bounce: key (row3,col1) low 3 cycles then high -> no key_strobe, key_code unchanged, scanning resumes at row 0.
4. Keys (row1,col1) and (row1,col3) pressed together -> single strobe, key_code=0101.
5. rst=1 for one cycle while in HOLD -> next cycle row_n=1110, key_held=0, key_code=0000; the key still being held is re-detected as a new press with one strobe.
6. KEYPAD_REPEAT_EN defined, key (row3,col1) held 60 cycles in HOLD -> initial strobe plus 3 repeat strobes at 16-cycle spacing, all key_code=1101; undefined -> only 1 strobe.
